// File: rtl/mem_stage_if.sv
// Data-memory port of the memory stage: req/gnt request channel plus rvalid/rdata response channel.
// The request holds steady from the cycle req rises until the cycle gnt is seen; rvalid is a one-cycle data strobe.
interface mem_stage_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int REG_WIDTH  = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-3:0] addr;
    logic [3:0]            be;
    logic [REG_WIDTH-1:0]  wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [REG_WIDTH-1:0]  rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the rrv RV32I pipeline: issues loads/stores on a req/gnt/rvalid port,
// aligns store data, extends load data and forwards the GPR write-back bundle.
module mem_stage #(
    parameter int REG_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_mem_en_mem,
    input  logic                      data_mem_we_mem,
    input  logic [ADDR_WIDTH-1:0]     addr_mem,
    input  logic [REG_WIDTH-1:0]      rs2_mem,
    input  logic [2:0]                funct3_mem,
    input  logic                      mem_wb,
    input  logic                      gpr_we_wb,
    input  logic [REG_ADDR_WIDTH-1:0] addr_rd_wb,
    input  logic [REG_WIDTH-1:0]      data_rd_wb,
    output logic                      mem_stall,
    mem_stage_if.master               dmem,
    output logic                      gpr_we_out,
    output logic [REG_ADDR_WIDTH-1:0] addr_rd_out,
    output logic [REG_WIDTH-1:0]      data_rd_out,
    output logic                      access_err,
    output logic [1:0]                state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    state_t state, state_next;

    logic                      op_we;
    logic [2:0]                op_f3;
    logic [1:0]                op_lane;
    logic [ADDR_WIDTH-3:0]     op_addr;
    logic [3:0]                op_be;
    logic [REG_WIDTH-1:0]      op_wdata;
    logic                      op_wb;
    logic [REG_ADDR_WIDTH-1:0] op_rd;

    logic                 aligned, legal_f3, op_ok, req_c, load_done;
    logic [3:0]           be_c;
    logic [REG_WIDTH-1:0] wdata_c, shifted, load_val;

    // Legality and lane placement of the incoming request
    always_comb begin
        aligned = 1'b0;
        be_c    = 4'b0000;
        wdata_c = rs2_mem;
        case (funct3_mem[1:0])
            2'b00: begin
                aligned = 1'b1;
                be_c    = 4'(4'b0001 << addr_mem[1:0]);
                wdata_c = {4{rs2_mem[7:0]}};
            end
            2'b01: begin
                aligned = ~addr_mem[0];
                be_c    = 4'(4'b0011 << addr_mem[1:0]);
                wdata_c = {2{rs2_mem[15:0]}};
            end
            2'b10: begin
                aligned = (addr_mem[1:0] == 2'b00);
                be_c    = 4'b1111;
            end
            default: aligned = 1'b0;
        endcase
        if (data_mem_we_mem)
            legal_f3 = ~funct3_mem[2] && (funct3_mem[1:0] != 2'b11);
        else
            legal_f3 = (funct3_mem[1:0] != 2'b11) && (funct3_mem != 3'b110);
        op_ok = aligned && legal_f3;
    end

    always_comb begin
        shifted = dmem.rdata >> {op_lane, 3'b000};
        case (op_f3)
            3'b000:  load_val = {{(REG_WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b100:  load_val = {{(REG_WIDTH-8){1'b0}}, shifted[7:0]};
            3'b001:  load_val = {{(REG_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b101:  load_val = {{(REG_WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: if (data_mem_en_mem && op_ok) state_next = REQ;
            REQ: begin
                req_c = 1'b1;
                if (dmem.gnt) begin
                    if (op_we) begin
                        state_next = IDLE;
                    end else if (dmem.rvalid) begin
                        load_done  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem.rvalid) begin
                    load_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_stall  = (state != IDLE);
    assign state_dbg  = state;
    assign dmem.req   = req_c;
    assign dmem.we    = req_c & op_we;
    assign dmem.addr  = req_c ? op_addr : '0;
    assign dmem.be    = req_c ? op_be : 4'b0000;
    assign dmem.wdata = req_c ? op_wdata : '0;

    // Inputs are only looked at in IDLE; REQ/WAIT hold a bubble until the load completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_we       <= 1'b0;
            op_f3       <= 3'b000;
            op_lane     <= 2'b00;
            op_addr     <= '0;
            op_be       <= 4'b0000;
            op_wdata    <= '0;
            op_wb       <= 1'b0;
            op_rd       <= '0;
            gpr_we_out  <= 1'b0;
            addr_rd_out <= '0;
            data_rd_out <= '0;
            access_err  <= 1'b0;
        end else begin
            access_err <= 1'b0;
            if (state == IDLE) begin
                if (!data_mem_en_mem) begin
                    gpr_we_out  <= gpr_we_wb;
                    addr_rd_out <= addr_rd_wb;
                    data_rd_out <= data_rd_wb;
                end else if (op_ok) begin
                    gpr_we_out <= 1'b0;
                    op_we      <= data_mem_we_mem;
                    op_f3      <= funct3_mem;
                    op_lane    <= addr_mem[1:0];
                    op_addr    <= addr_mem[ADDR_WIDTH-1:2];
                    op_be      <= be_c;
                    op_wdata   <= wdata_c;
                    op_wb      <= gpr_we_wb & mem_wb;
                    op_rd      <= addr_rd_wb;
                end else begin
                    gpr_we_out <= 1'b0;
                    access_err <= 1'b1;
                end
            end else if (load_done) begin
                gpr_we_out  <= op_wb;
                addr_rd_out <= op_rd;
                data_rd_out <= load_val;
            end else begin
                gpr_we_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: pass-through, table of load/store/error vectors against a
// scripted memory responder, and a reset-during-transaction sequence.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        data_mem_en_mem, data_mem_we_mem, mem_wb, gpr_we_wb;
    logic [9:0]  addr_mem;
    logic [31:0] rs2_mem, data_rd_wb;
    logic [2:0]  funct3_mem;
    logic [4:0]  addr_rd_wb;
    logic        mem_stall, gpr_we_out, access_err;
    logic [4:0]  addr_rd_out;
    logic [31:0] data_rd_out;
    logic [1:0]  state_dbg;

    mem_stage_if #(.ADDR_WIDTH(10), .REG_WIDTH(32)) dmem ();

    mem_stage dut (
        .clk(clk), .rst(rst),
        .data_mem_en_mem(data_mem_en_mem), .data_mem_we_mem(data_mem_we_mem),
        .addr_mem(addr_mem), .rs2_mem(rs2_mem), .funct3_mem(funct3_mem), .mem_wb(mem_wb),
        .gpr_we_wb(gpr_we_wb), .addr_rd_wb(addr_rd_wb), .data_rd_wb(data_rd_wb),
        .mem_stall(mem_stall), .dmem(dmem),
        .gpr_we_out(gpr_we_out), .addr_rd_out(addr_rd_out), .data_rd_out(data_rd_out),
        .access_err(access_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [9:0]  addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        gpr_we;
        logic        mem_wb;
        logic [4:0]  rd;
        logic        err;
        logic [7:0]  waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        wb_we;
        logic [31:0] wb_data;
    } vec_t;

    vec_t        vecs[15];
    logic [37:0] exp_q[$];
    int          passed = 0;
    int          total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Pops the next expected write-back; rd/data only matter when a write is expected or full is set
    task automatic wb_compare(input string name, input bit full);
        logic [37:0] e;
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL %s: actual=empty_queue required=entry", name);
        end else begin
            e = exp_q.pop_front();
            check({name, "_we"}, {31'b0, gpr_we_out}, {31'b0, e[37]});
            if (e[37] || full) begin
                check({name, "_rd"}, {27'b0, addr_rd_out}, {27'b0, e[36:32]});
                check({name, "_data"}, data_rd_out, e[31:0]);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string n;
        n = $sformatf("v%0d", idx);
        @(negedge clk);
        data_mem_en_mem = 1'b1;
        data_mem_we_mem = v.we;
        funct3_mem      = v.f3;
        addr_mem        = v.addr;
        rs2_mem         = v.rs2;
        gpr_we_wb       = v.gpr_we;
        mem_wb          = v.mem_wb;
        addr_rd_wb      = v.rd;
        data_rd_wb      = 32'h5A5A5A5A;
        exp_q.push_back({v.wb_we, v.rd, v.wb_data});
        @(posedge clk);
        if (v.err) begin
            @(negedge clk);
            data_mem_en_mem = 1'b0;
            gpr_we_wb       = 1'b0;
            check({n, "_err"}, {31'b0, access_err}, 32'd1);
            check({n, "_err_req"}, {31'b0, dmem.req}, 32'd0);
            check({n, "_err_stall"}, {31'b0, mem_stall}, 32'd0);
            wb_compare({n, "_err_wb"}, 1'b0);
            @(negedge clk);
            check({n, "_err_pulse"}, {31'b0, access_err}, 32'd0);
            check({n, "_err_req2"}, {31'b0, dmem.req}, 32'd0);
        end else begin
            for (int c = 0; c <= v.gnt_dly; c++) begin
                @(negedge clk);
                data_mem_en_mem = 1'b0;
                gpr_we_wb       = 1'b0;
                check($sformatf("%s_req_stall%0d", n, c), {31'b0, mem_stall}, 32'd1);
                check($sformatf("%s_req%0d", n, c), {31'b0, dmem.req}, 32'd1);
                check($sformatf("%s_we%0d", n, c), {31'b0, dmem.we}, {31'b0, v.we});
                check($sformatf("%s_addr%0d", n, c), {24'b0, dmem.addr}, {24'b0, v.waddr});
                check($sformatf("%s_be%0d", n, c), {28'b0, dmem.be}, {28'b0, v.be});
                if (v.we) check($sformatf("%s_wdata%0d", n, c), dmem.wdata, v.wdata);
                check($sformatf("%s_bubble%0d", n, c), {31'b0, gpr_we_out}, 32'd0);
                if (c == v.gnt_dly) begin
                    dmem.gnt = 1'b1;
                    if (!v.we && v.rv_dly == 0) begin
                        dmem.rvalid = 1'b1;
                        dmem.rdata  = v.rdata;
                    end
                end
                @(posedge clk);
            end
            @(negedge clk);
            dmem.gnt    = 1'b0;
            dmem.rvalid = 1'b0;
            if (!v.we) begin
                for (int c = 1; c <= v.rv_dly; c++) begin
                    check($sformatf("%s_wait_stall%0d", n, c), {31'b0, mem_stall}, 32'd1);
                    check($sformatf("%s_wait_req%0d", n, c), {31'b0, dmem.req}, 32'd0);
                    if (c == v.rv_dly) begin
                        dmem.rvalid = 1'b1;
                        dmem.rdata  = v.rdata;
                    end
                    @(posedge clk);
                    @(negedge clk);
                    dmem.rvalid = 1'b0;
                    dmem.rdata  = 32'h0;
                end
            end
            check({n, "_done_stall"}, {31'b0, mem_stall}, 32'd0);
            check({n, "_done_req"}, {31'b0, dmem.req}, 32'd0);
            wb_compare({n, "_wb"}, 1'b0);
        end
    endtask

    initial begin
        //          we    f3      addr     rs2           rdata         g  r  gwe   mwb   rd     err   waddr  be       wdata         wb_we wb_data
        vecs[0]  = '{1'b1, 3'b000, 10'h0F3, 32'h000000AB, 32'h0,        0, 0, 1'b1, 1'b0, 5'd1,  1'b0, 8'h3C, 4'b1000, 32'hABABABAB, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 10'h002, 32'h0,        32'h00800000, 2, 3, 1'b1, 1'b1, 5'd7,  1'b0, 8'h00, 4'b0100, 32'h0,        1'b1, 32'hFFFFFF80};
        vecs[2]  = '{1'b0, 3'b100, 10'h002, 32'h0,        32'h00800000, 2, 3, 1'b1, 1'b1, 5'd8,  1'b0, 8'h00, 4'b0100, 32'h0,        1'b1, 32'h00000080};
        vecs[3]  = '{1'b0, 3'b001, 10'h001, 32'h0,        32'h0,        0, 0, 1'b1, 1'b1, 5'd2,  1'b1, 8'h00, 4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[4]  = '{1'b0, 3'b010, 10'h010, 32'h0,        32'hDEADBEEF, 0, 0, 1'b1, 1'b1, 5'd3,  1'b0, 8'h04, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 3'b001, 10'h0A2, 32'h1234BEEF, 32'h0,        1, 0, 1'b1, 1'b0, 5'd1,  1'b0, 8'h28, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 3'b010, 10'h3FC, 32'hCAFEBABE, 32'h0,        0, 0, 1'b0, 1'b0, 5'd0,  1'b0, 8'hFF, 4'b1111, 32'hCAFEBABE, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 3'b001, 10'h006, 32'h0,        32'h80017FFF, 0, 1, 1'b1, 1'b1, 5'd9,  1'b0, 8'h01, 4'b1100, 32'h0,        1'b1, 32'hFFFF8001};
        vecs[8]  = '{1'b0, 3'b101, 10'h006, 32'h0,        32'h80017FFF, 1, 2, 1'b1, 1'b1, 5'd10, 1'b0, 8'h01, 4'b1100, 32'h0,        1'b1, 32'h00008001};
        vecs[9]  = '{1'b0, 3'b000, 10'h001, 32'h0,        32'h00007F00, 0, 0, 1'b1, 1'b0, 5'd11, 1'b0, 8'h00, 4'b0010, 32'h0,        1'b0, 32'h0};
        vecs[10] = '{1'b1, 3'b011, 10'h000, 32'h11111111, 32'h0,        0, 0, 1'b1, 1'b0, 5'd4,  1'b1, 8'h00, 4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b0, 3'b110, 10'h000, 32'h0,        32'h0,        0, 0, 1'b1, 1'b1, 5'd5,  1'b1, 8'h00, 4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[12] = '{1'b1, 3'b010, 10'h002, 32'h22222222, 32'h0,        0, 0, 1'b1, 1'b0, 5'd6,  1'b1, 8'h00, 4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[13] = '{1'b0, 3'b010, 10'h3FF, 32'h0,        32'h0,        0, 0, 1'b1, 1'b1, 5'd7,  1'b1, 8'h00, 4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[14] = '{1'b0, 3'b000, 10'h107, 32'h0,        32'h7F000000, 1, 0, 1'b1, 1'b1, 5'd12, 1'b0, 8'h41, 4'b1000, 32'h0,        1'b1, 32'h0000007F};

        rst             = 1'b1;
        data_mem_en_mem = 1'b0;
        data_mem_we_mem = 1'b0;
        addr_mem        = '0;
        rs2_mem         = '0;
        funct3_mem      = 3'b000;
        mem_wb          = 1'b0;
        gpr_we_wb       = 1'b0;
        addr_rd_wb      = '0;
        data_rd_wb      = '0;
        dmem.gnt        = 1'b0;
        dmem.rvalid     = 1'b0;
        dmem.rdata      = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_stall", {31'b0, mem_stall}, 32'd0);
        check("rst_req", {31'b0, dmem.req}, 32'd0);
        check("rst_be", {28'b0, dmem.be}, 32'd0);
        check("rst_gpr_we", {31'b0, gpr_we_out}, 32'd0);
        check("rst_data", data_rd_out, 32'd0);
        check("rst_err", {31'b0, access_err}, 32'd0);
        check("rst_state", {30'b0, state_dbg}, 32'd0);
        rst = 1'b0;

        // ALU pass-through, back to back, one directed then random
        for (int i = 0; i < 10; i++) begin
            logic        g;
            logic [4:0]  r;
            logic [31:0] d;
            @(negedge clk);
            if (i > 0) begin
                wb_compare($sformatf("pass%0d", i - 1), 1'b1);
                check($sformatf("pass_stall%0d", i - 1), {31'b0, mem_stall}, 32'd0);
            end
            if (i == 0) begin
                g = 1'b1;
                r = 5'd5;
                d = 32'h12345678;
            end else begin
                g = 1'($urandom_range(0, 1));
                r = 5'($urandom_range(0, 31));
                d = $urandom;
            end
            data_mem_en_mem = 1'b0;
            gpr_we_wb       = g;
            addr_rd_wb      = r;
            data_rd_wb      = d;
            exp_q.push_back({g, r, d});
        end
        @(negedge clk);
        wb_compare("pass9", 1'b1);
        gpr_we_wb = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Reset while waiting for read data, then a stale rvalid
        @(negedge clk);
        data_mem_en_mem = 1'b1;
        data_mem_we_mem = 1'b0;
        funct3_mem      = 3'b010;
        addr_mem        = 10'h020;
        gpr_we_wb       = 1'b1;
        mem_wb          = 1'b1;
        addr_rd_wb      = 5'd4;
        @(posedge clk);
        @(negedge clk);
        data_mem_en_mem = 1'b0;
        gpr_we_wb       = 1'b0;
        dmem.gnt        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dmem.gnt = 1'b0;
        check("mid_wait_stall", {31'b0, mem_stall}, 32'd1);
        check("mid_wait_state", {30'b0, state_dbg}, 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_req", {31'b0, dmem.req}, 32'd0);
        check("mid_rst_stall", {31'b0, mem_stall}, 32'd0);
        check("mid_rst_state", {30'b0, state_dbg}, 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        gpr_we_wb   = 1'b0;
        addr_rd_wb  = 5'd0;
        data_rd_wb  = 32'h11111111;
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        dmem.rvalid = 1'b0;
        check("stale_gpr_we", {31'b0, gpr_we_out}, 32'd0);
        check("stale_data", data_rd_out, 32'h11111111);
        check("stale_stall", {31'b0, mem_stall}, 32'd0);
        check("stale_req", {31'b0, dmem.req}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the rrv RV32I pipeline, sitting between execution and write-back.
- Consumes the registered load/store request fields that execution drives (data_mem_en_mem, data_mem_we_mem, addr_mem, rs2_mem, funct3_mem, mem_wb) and performs the access on a req/gnt/rvalid data-memory port.
- Generates byte enables, sign/zero-extends load data and forwards the GPR write-back bundle.
- Stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
- REG_WIDTH, 32, data/GPR width.
- ADDR_WIDTH, 10, byte-address width of addr_mem (clog2 of DATA_DEPTH).
- REG_ADDR_WIDTH, 5, GPR index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- data_mem_en_mem  in  1  memory op present.
- data_mem_we_mem  in  1  1 = store, 0 = load.
- addr_mem  in  ADDR_WIDTH  byte address.
- rs2_mem  in  REG_WIDTH  store data, low-aligned.
- funct3_mem  in  3  access size/sign.
- mem_wb  in  1  load result goes to rd.
- gpr_we_wb  in  1  GPR write enable from execution.
- addr_rd_wb  in  REG_ADDR_WIDTH  rd index.
- data_rd_wb  in  REG_WIDTH  ALU result for non-load ops.
- mem_stall  out  1  upstream must hold its outputs.
- dmem_req  out  1  request valid.
- dmem_we  out  1  write.
- dmem_addr  out  ADDR_WIDTH-2  word address.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  REG_WIDTH  lane-shifted store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  REG_WIDTH  read word.
- gpr_we_out  out  1  write-back enable.
- addr_rd_out  out  REG_ADDR_WIDTH  rd index.
- data_rd_out  out  REG_WIDTH  write-back data.
- access_err  out  1  one-cycle pulse on misaligned access or illegal funct3.

Behaviour:
- Reset (async, immediate): state = IDLE. All outputs are 0: mem_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, gpr_we_out, addr_rd_out, data_rd_out, access_err.
- FSM states: IDLE, REQ, WAIT. mem_stall = (state != IDLE), driven combinationally from state. Inputs are sampled only on edges where state == IDLE.
- IDLE, data_mem_en_mem = 0: pass-through, 1-cycle latency. gpr_we_out <= gpr_we_wb, addr_rd_out <= addr_rd_wb, data_rd_out <= data_rd_wb. Stay in IDLE.
- IDLE, data_mem_en_mem = 1, legal and aligned: capture the op and go to REQ. Write-back outputs become a bubble (gpr_we_out = 0).
- Legality:
  - funct3 000/100: any lane.
  - 001/101: addr[0] = 0.
  - 010: addr[1:0] = 0.
  - Loads: 011/110/111 illegal. Stores: only 000/001/010 legal.
  - Illegal or misaligned: access_err pulses for 1 cycle, no dmem request, gpr_we_out = 0, stay in IDLE.
- REQ:
  - dmem_req = 1, dmem_addr = addr[ADDR_WIDTH-1:2]; all request outputs are held stable until dmem_gnt.
  - Byte enables: SB be = 0001 << lane, SH be = 0011 << lane, SW be = 1111.
  - dmem_wdata = rs2 replicated (byte ×4, half ×2) so it lands on the enabled lanes.
  - On dmem_gnt, store: done, go to IDLE, dmem_req drops next cycle.
  - On dmem_gnt, load: go to WAIT.
  - dmem_gnt and dmem_rvalid in the same REQ cycle (zero-latency memory): complete the load directly and go to IDLE.
- WAIT:
  - dmem_req = 0.
  - On dmem_rvalid: select the byte/half by lane and extend. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Register the result: data_rd_out <= extended value, gpr_we_out <= gpr_we & mem_wb, addr_rd_out <= captured rd. Go to IDLE.
- dmem_rvalid seen in IDLE or REQ without a pending load is ignored. This covers stale responses after a reset.
- Latency from sampling edge to write-back outputs:
  - Store: 1 + gnt wait; no write-back.
  - Load: 2 + gnt wait + rvalid wait (minimum 2 with zero-latency memory).
- A reset asserted mid-transaction aborts it. dmem_req drops asynchronously and nothing is written back.

Test Plan:
- ALU pass-through: en = 0, gpr_we = 1, rd = 5, data = 0x12345678 -> next cycle gpr_we_out = 1, addr_rd_out = 5, data_rd_out = 0x12345678; mem_stall stays 0.
- SB: addr 0x0F3, rs2 = 0xAB, gnt same cycle as req -> dmem_addr = 0x3C, be = 1000, wdata = 0xABABABAB, dmem_we = 1; mem_stall high for exactly 1 cycle; no write-back.
- LB/LBU: addr 0x002, rdata = 0x00800000 -> LB gives 0xFFFFFF80, LBU gives 0x00000080. Check with gnt delayed 2 cycles and rvalid delayed 3 cycles; mem_stall stays high throughout.
- LH: addr 0x001 -> access_err pulses for 1 cycle, dmem_req never asserts, gpr_we_out = 0.
- LW with zero-latency memory: gnt and rvalid together, rdata = 0xDEADBEEF -> data_rd_out = 0xDEADBEEF two cycles after sampling.
- Reset mid-transaction: assert rst while in WAIT -> dmem_req and mem_stall are 0 immediately. A later rvalid is ignored and gpr_we_out stays 0.
